// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames bytes, and decodes
// E0/F0/E1 prefixes into an 11-bit key event. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 49152
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, dat_filt, clk_filt_d;
  logic [FW-1:0] clk_fcnt, dat_fcnt;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_good;
  logic [TW-1:0] tmo_cnt;
  logic          byte_stb, stb_next, err_next;
  logic          ext_flag, brk_flag;
  logic [2:0]    skip_cnt;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  // Each filter flips only on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + FW'(1);
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dat_filt <= 1'b1;
      dat_fcnt <= '0;
    end else if (dat_s2 == dat_filt) begin
      dat_fcnt <= '0;
    end else if (dat_fcnt == FW'(FILTER_LEN - 1)) begin
      dat_filt <= dat_s2;
      dat_fcnt <= '0;
    end else begin
      dat_fcnt <= dat_fcnt + FW'(1);
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  always_comb begin
    next_state = state;
    stb_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE:    if (fall && !dat_filt) next_state = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) next_state = PARITY;
      PARITY:  if (fall) next_state = STOP;
      STOP: begin
        if (fall) begin
          next_state = IDLE;
          if (dat_filt && par_good) stb_next = 1'b1;
          else err_next = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    // A stalled frame is abandoned; an edge arriving in the same cycle still wins.
    if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      next_state = IDLE;
      stb_next   = 1'b0;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      clk_filt_d <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      par_good   <= 1'b0;
      tmo_cnt    <= '0;
      byte_stb   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= next_state;
      clk_filt_d <= clk_filt;
      byte_stb   <= stb_next;
      frame_err  <= err_next;
      if (fall || state == IDLE) tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par_good <= ^{shift, dat_filt};
`else
          PARITY: par_good <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // The shift register still holds the finished byte while byte_stb is high.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      ps2_key  <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      skip_cnt <= '0;
    end else if (byte_stb) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else begin
        case (shift)
          8'hE0: ext_flag <= 1'b1;
          8'hF0: brk_flag <= 1'b1;
          8'hE1: skip_cnt <= 3'd7;
          8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
          default: begin
            ps2_key  <= {~ps2_key[10], ~brk_flag, ext_flag, shift};
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, giving the consecutive equal clk_49m samples needed to accept a PS/2 line level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 49152, giving the maximum clk_49m cycles between PS/2 clock falling edges inside a frame.
REQ-003 SHALL have port clk_49m  input  1  single system clock; all logic is in this one clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line, asynchronous, idle high.
REQ-006 SHALL have port ps2_data_in  input  1  raw PS/2 data line, asynchronous, idle high.
REQ-007 SHALL have port ps2_key  output  11  key event {toggle[10], pressed[9], extended[8], code[7:0]}, in the format consumed by the core keyboard decoders.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse for each discarded malformed frame.

Function
REQ-009 SHALL pass both PS/2 lines through a 2-flop synchronizer, then a filter that changes its output only after FILTER_LEN consecutive equal synchronized samples.
REQ-010 SHALL treat a 1->0 transition of the filtered clock as a falling edge and SHALL sample filtered data on that clk_49m cycle.
REQ-011 SHALL run receive FSM states IDLE, DATA, PARITY, STOP, with transitions below.
REQ-012 IDLE: on a falling edge with data 0, SHALL go to DATA and clear the bit counter; with data 1, SHALL stay in IDLE and SHALL NOT pulse frame_err.
REQ-013 DATA: SHALL shift in 8 bits LSB-first on 8 falling edges, then go to PARITY.
REQ-014 PARITY: SHALL capture the parity bit and go to STOP.
REQ-015 STOP: on the next falling edge, with data 1 and parity valid, SHALL raise an internal byte strobe for one cycle; otherwise SHALL discard the frame and pulse frame_err; SHALL return to IDLE in both cases.
REQ-016 SHALL reload the timeout counter on every falling edge; outside IDLE, when the count reaches TIMEOUT_CYCLES, SHALL return to IDLE, discard the partial byte and pulse frame_err.
REQ-017 On the byte strobe, the decoder SHALL act on the received byte:
- E0: set the extended flag.
- F0: set the break flag. Flag order (E0 F0 or F0 E0) is irrelevant.
- E1: load a skip counter with 7.
- AA, FA, FE, EE, 00, FF: ignore and clear both flags.
REQ-018 While the skip counter is non-zero, the decoder SHALL decrement it per received byte, drop the byte, and leave the flags and ps2_key unchanged.
REQ-019 For any other byte, ps2_key SHALL update one clk_49m cycle after the byte strobe: code = byte, extended = flag, pressed = ~break flag, toggle inverted; both flags SHALL then clear.
REQ-020 ps2_key SHALL hold between events; bit 10 SHALL change exactly once per reported event.
REQ-021 frame_err and a valid byte strobe SHALL never occur in the same cycle.

Reset
REQ-022 While reset is low:
- ps2_key and frame_err SHALL be 0.
- FSM SHALL be IDLE; bit counter, timeout counter, flags and skip counter SHALL be 0.
- Synchronizers and filters SHALL be preset to 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no ps2_key change and no frame_err pulse.

Configuration
REQ-024 With PS2_PARITY_CHECK_EN defined, parity SHALL be valid only when the 8 data bits plus the parity bit contain an odd number of ones; a frame with bad parity SHALL be discarded with a frame_err pulse.
REQ-025 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and only the stop bit SHALL qualify the frame.

Verification
REQ-026 Frame 0x1C with good parity and stop 1 -> ps2_key = 0x61C (toggle 1, pressed 1, ext 0) one cycle after the strobe; frame_err stays 0.
REQ-027 Bytes E0, F0, 75 -> ps2_key[9:0] = 0x175, toggle inverted once; a following 75 -> pressed 1, ext 0, toggle inverted again.
REQ-028 Bytes E1 14 77 E1 F0 14 F0 77, then 16 -> only 16 is reported; ps2_key[7:0] = 0x16.
REQ-029 Frame 0x1C with even parity -> with PS2_PARITY_CHECK_EN: one frame_err pulse, ps2_key unchanged; without it: key 0x1C reported.
REQ-030 Five bits of a frame, then clock held high for TIMEOUT_CYCLES -> frame_err pulses once; a following clean 0x29 frame -> ps2_key[7:0] = 0x29.
REQ-031 Glitch of FILTER_LEN-1 cycles low on ps2_clk_in -> no edge detected; reset asserted after 4 data bits -> ps2_key = 0, FSM IDLE.
